// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and sizing helper for the BCD converter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bcd_pkg;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] BCD_BLANK   = 4'hF;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Minimum number of decimal digits needed to hold 2^w-1.
  function automatic int digits_for_width(input int w);
    longint unsigned maxv;
    int              d;
    maxv = (64'd1 << w) - 64'd1;
    d    = 1;
    for (int i = 0; i < 20; i++) begin
      if (maxv >= 64'd10) begin
        maxv = maxv / 64'd10;
        d    = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added (4-bit wrap).
// Latency: combinational.
// Backpressure: none.
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] fixed
);

  // Pre-shift correction so the following left shift carries into the next digit.
  always_comb begin
    fixed = digit;
    if (digit >= ADD3_THRESH) fixed = digit + 4'd3;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: start accepted at edge k -> done pulse and bcd valid after edge k+WIDTH.
// Backpressure: start is ignored while busy; optional leading-zero blanking via BIN2BCD_LZ_BLANK_EN.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH-1:0]              bin,
  output logic                          busy,
  output logic                          done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

  localparam int BW    = BCD_DIGIT_W * DIGITS;
  localparam int SW    = BW + WIDTH;
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  // Refuse to build a converter whose digit field cannot hold the largest input.
  if (WIDTH < 2) begin : g_width_chk
    $error("bin_to_bcd_seq: WIDTH must be at least 2");
  end
  if (DIGITS < digits_for_width(WIDTH)) begin : g_digits_chk
    $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
  end

  state_t            state;
  state_t            state_nxt;
  logic [SW-1:0]     sreg;
  logic [SW-1:0]     sreg_add;
  logic [SW-1:0]     sreg_shl;
  logic [CNT_W-1:0]  cnt;
  logic              load;
  logic              last;
  logic [BW-1:0]     result;

  // Correction cells only touch the BCD digit fields, never the unshifted binary part.
  assign sreg_add[WIDTH-1:0] = sreg[WIDTH-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_add3
    bcd_add3 u_add3 (
      .digit (sreg[WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W]),
      .fixed (sreg_add[WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W])
    );
  end

  assign sreg_shl = {sreg_add[SW-2:0], 1'b0};

`ifdef BIN2BCD_LZ_BLANK_EN
  logic lead;

  // Blank leading zero digits from the top down; digit 0 always shows.
  always_comb begin
    result = sreg_shl[SW-1:WIDTH];
    lead   = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (sreg_shl[WIDTH+BCD_DIGIT_W*i +: BCD_DIGIT_W] == 4'd0)) begin
        result[BCD_DIGIT_W*i +: BCD_DIGIT_W] = BCD_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
  end
`else
  assign result = sreg_shl[SW-1:WIDTH];
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: accept start only from IDLE, return after the final shift.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)          state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)      state_nxt = IDLE;
      default:                     state_nxt = IDLE;
    endcase
  end

  // Decoded FSM outputs.
  always_comb begin
    busy = (state == SHIFT);
    load = (state == IDLE) && start;
    last = (state == SHIFT) && (cnt == '0);
  end

  // Shift register, bit counter and registered result/done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg <= '0;
      cnt  <= '0;
      done <= 1'b0;
      bcd  <= '0;
    end else begin
      done <= 1'b0;
      if (load) begin
        sreg <= {{BW{1'b0}}, bin};
        cnt  <= CNT_W'(WIDTH - 1);
      end else if (state == SHIFT) begin
        sreg <= sreg_shl;
        cnt  <= cnt - 1'b1;
      end
      if (last) begin
        bcd  <= result;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomized and directed bench for bin_to_bcd_seq (8-bit/3-digit and 10-bit/4-digit instances).
// Latency: checks done arrives WIDTH cycles after the accepted start.
// Backpressure: checks start-while-busy is dropped and back-to-back starts are taken.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  logic        start10;
  logic [9:0]  bin10;
  logic        busy10;
  logic        done10;
  logic [15:0] bcd10;

  int nchecks = 0;
  int nerrors = 0;

  bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  bin_to_bcd_seq #(.WIDTH(10), .DIGITS(4)) dut10 (
    .clk   (clk),
    .rst   (rst),
    .start (start10),
    .bin   (bin10),
    .busy  (busy10),
    .done  (done10),
    .bcd   (bcd10)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Decimal digits by division; optional leading-zero blanking.
  function automatic logic [15:0] ref_bcd(input int v, input int nd);
    logic [15:0] r;
    int          x;
    bit          lead;
    r = '0;
    x = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef BIN2BCD_LZ_BLANK_EN
    lead = 1'b1;
    for (int i = nd - 1; i >= 1; i--) begin
      if (lead && r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count cycles from the accept edge until done shows, bounded.
  task automatic wait_done(output int n, output int nbusy);
    n = 0;
    nbusy = 0;
    while (!done && n < 40) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
  endtask

  task automatic run(input int v, input logic [11:0] exp, input string tag);
    int n, nb;
    start = 1'b1;
    bin   = 8'(v);
    tick();
    start = 1'b0;
    bin   = 8'($urandom);
    wait_done(n, nb);
    chk({tag, "_lat"}, n, 8);
    chk({tag, "_busycyc"}, nb, 8);
    chk({tag, "_bcd"}, bcd, exp);
    chk({tag, "_busy_at_done"}, busy, 0);
    tick();
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic count_done(input int cycles, output int ndone);
    ndone = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done) ndone++;
    end
  endtask

  int order[256];
  int n, nb, nd, v, j, t;

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; start10 = 1'b0; bin10 = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bcd", bcd, 0);
    chk("rst_bcd10", bcd10, 0);
    rst = 1'b0;
    tick();

`ifdef BIN2BCD_LZ_BLANK_EN
    run(0,   12'hFF0, "dir0");
    run(99,  12'hF99, "dir99");
    run(7,   12'hFF7, "dir7");
`else
    run(0,   12'h000, "dir0");
    run(99,  12'h099, "dir99");
    run(7,   12'h007, "dir7");
`endif
    run(255, 12'h255, "dir255");
    run(128, 12'h128, "dir128");
    run(105, 12'h105, "dir105");

    // Exhaustive sweep in shuffled order.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 256; i++) run(order[i], 12'(ref_bcd(order[i], 3)), "sweep");

    // Start during a conversion is dropped.
    start = 1'b1; bin = 8'd42; tick(); start = 1'b0;
    tick(); tick(); tick();
    start = 1'b1; bin = 8'd7; tick(); start = 1'b0;
    wait_done(n, nb);
    chk("ign_lat", n + 4, 8);
    chk("ign_bcd", bcd, 12'h042);
    count_done(15, nd);
    chk("ign_no_second_done", nd, 0);
    chk("ign_bcd_held", bcd, 12'h042);

    // Back-to-back: new start on the done cycle.
    start = 1'b1; bin = 8'd17; tick(); start = 1'b0;
    wait_done(n, nb);
    chk("b2b_first_lat", n, 8);
    chk("b2b_first_bcd", bcd, 12'h017);
    start = 1'b1; bin = 8'd200; tick(); start = 1'b0;
    chk("b2b_accepted", busy, 1);
    chk("b2b_pulse", done, 0);
    wait_done(n, nb);
    chk("b2b_second_lat", n, 8);
    chk("b2b_second_bcd", bcd, 12'h200);
    tick();

    // Reset in the middle of a conversion.
    start = 1'b1; bin = 8'd123; tick(); start = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_bcd", bcd, 0);
    count_done(15, nd);
    chk("abort_no_done", nd, 0);
    v = int'($urandom_range(255, 1));
    run(v, 12'(ref_bcd(v, 3)), "post_abort");

    // Wider instance: 10-bit input, 4 digits.
    for (int k = 0; k < 12; k++) begin
      v = (k == 0) ? 1023 : int'($urandom_range(1023, 0));
      start10 = 1'b1; bin10 = 10'(v); tick(); start10 = 1'b0; bin10 = 10'($urandom);
      n = 0;
      while (!done10 && n < 40) begin
        tick();
        n++;
      end
      chk("w10_lat", n, 10);
      chk("w10_bcd", bcd10, ref_bcd(v, 4));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Iterative binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock.
- Inverse of the team's combinational BCD-to-binary block. Sits between datapath counters/ALU results and BCD display/readout logic.
- Trades latency (WIDTH cycles) for area. A start/busy/done handshake lets a controller sequence conversions.

Parameters:
- WIDTH, 8, binary input width in bits (>= 2).
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1; a violation is an elaboration-time error.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a conversion; sampled only while idle.
- bin  input  WIDTH  unsigned binary value; captured on the accepted start edge only.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd is updated.
- bcd  output  4*DIGITS  packed BCD result; digit 0 = bcd[3:0] (least significant). Held until the next completion.

Behaviour:
- Interface (already decided): one clock (clk); reset rst is synchronous and active-high.
- Reset: the following take effect at the first clk edge with rst=1, and rst overrides all other inputs.
  - State to IDLE.
  - busy=0, done=0, bcd=0.
  - Internal shift register and bit counter cleared.
- FSM has two states, IDLE and SHIFT.
- IDLE:
  - On an edge with start=1: load shift register = {DIGITS*4 zeros, bin}, counter = WIDTH-1, go to SHIFT, busy=1.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Every BCD digit field >= 5 has 3 added (4-bit, no carry out).
  - The whole register then shifts left by 1.
  - Counter decrements.
- Completion: on the edge where the counter is 0, the final shift is performed and, on that same edge:
  - bcd <= upper 4*DIGITS bits of the result;
  - done <= 1 for exactly one cycle;
  - busy <= 0;
  - state <= IDLE.
- Latency: start sampled at edge k gives done=1 and a valid bcd in the cycle following edge k+WIDTH. Throughput is one conversion per WIDTH cycles.
- start while busy=1 is ignored and not queued. bin changes while busy=1 have no effect.
- start=1 in the cycle where done=1 (state is IDLE) is accepted; this is the back-to-back case.
- Reset mid-conversion aborts the conversion: no done pulse, and bcd is cleared to 0.
- Width rules: bin is unsigned. The add-3 correction is never applied to the unshifted binary field.

Optional Feature:
- Macro: BIN2BCD_LZ_BLANK_EN.
- When defined: on the completion edge, leading zero digits are replaced with 4'hF (blank code for downstream 7-segment drivers).
  - Scan runs from the most significant digit down, stopping at the first nonzero digit.
  - Digit 0 is never blanked, so a value of 0 yields {F,...,F,0}.
- When undefined: bcd carries plain BCD with leading zeros; there is no extra logic.
- busy, done and latency are identical in both builds.

Decomposition:
- Shared package bcd_pkg:
  - BCD_DIGIT_W = 4.
  - ADD3_THRESH = 4'd5.
  - BCD_BLANK = 4'hF.
  - Function digits_for_width(w), returning the minimum digit count, used for the DIGITS assertion.
  - FSM state typedef {IDLE, SHIFT}.
- Sub-module bcd_add3: combinational 4-bit "if >= 5 then +3" cell, instantiated DIGITS times in a generate loop.

Test Plan:
- bin=8'd0, start pulse at edge k -> busy 1 for 8 cycles; done one cycle after edge k+8; bcd=12'h000.
- bin=8'd255 -> bcd=12'h255. bin=8'd99 -> bcd=12'h099. bin=8'd128 -> bcd=12'h128. Exhaustive sweep 0..255 compared against a reference model.
- start asserted again 3 cycles into a conversion of 8'd42 with bin=8'd7 -> ignored; result 12'h042 at the original done time; no second done pulse.
- Back-to-back: start=1 with bin=8'd200 on the done cycle of the 8'd17 conversion -> 12'h017, then 12'h200 exactly 8 cycles later.
- rst=1 for one cycle, 4 cycles into a conversion -> busy=0, bcd=0, no done pulse. A new start then converts correctly.
- With BIN2BCD_LZ_BLANK_EN defined: bin=7 gives 12'hFF7; bin=0 gives 12'hFF0; bin=105 gives 12'h105. Also WIDTH=10, DIGITS=4: bin=1023 gives 16'h1023 after 10 cycles.
